// File: rtl/frame_rate_monitor.sv
// Multi-channel VS frame-rate meter: counts VS rising edges per CLK_HZ-cycle window and shows one
// channel on active-low 7-seg digits. Optional leading-zero blanking: define FRM_LZ_BLANK_EN.
module frame_rate_monitor #(
    parameter int CLK_HZ = 50_000_000,
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 10,
    parameter int DIGITS = 3
) (
    input  logic                     iCLK,
    input  logic                     iRST_N,
    input  logic [NUM_CH-1:0]        iVS,
    input  logic [2:0]               iSEL,
    output logic [NUM_CH*CNT_W-1:0]  oFPS,
    output logic [NUM_CH-1:0]        oSTALL,
    output logic                     oVALID,
    output logic [DIGITS*7-1:0]      oHEX
);

    localparam int WCNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int NB_MIN = (CNT_W + 2) / 3;
    localparam int NB     = (NB_MIN > DIGITS) ? NB_MIN : DIGITS;
    localparam int SH_W   = $clog2(CNT_W + 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(CLK_HZ - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [31:0]       OVF_LIM   = 32'(10 ** DIGITS);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, SEG} state_t;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    logic [NUM_CH-1:0]             meta_q, sync_q, dly_q, vs_rise;
    logic [WCNT_W-1:0]             wcnt_q, wcnt_d;
    logic                          tick;
    logic [NUM_CH-1:0][CNT_W-1:0]  cnt_q, cnt_d, fps_q, fps_d, cnt_inc;
    logic [NUM_CH-1:0]             stall_q, stall_d;

    state_t                        state_q, state_d;
    logic                          pend_q, pend_d;
    logic [CNT_W-1:0]              bin_q, bin_d, sel_val;
    logic [NB*4-1:0]               bcd_q, bcd_d, bcd_adj, bcd_shift;
    logic [SH_W-1:0]               sh_q, sh_d;
    logic                          ovf_q, ovf_d;
    logic [DIGITS*7-1:0]           hex_q, hex_d, hex_new;
    logic                          valid_q, valid_d;

    // Edge is taken from the synchronised level so a VS change is counted 3 clocks later.
    assign vs_rise = sync_q & ~dly_q;
    assign tick    = (wcnt_q == WCNT_LAST);
    assign wcnt_d  = tick ? '0 : wcnt_q + 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign cnt_inc[gi] = (vs_rise[gi] && cnt_q[gi] != CNT_MAX) ? cnt_q[gi] + 1'b1 : cnt_q[gi];
            assign cnt_d[gi]   = tick ? '0 : cnt_inc[gi];
            assign fps_d[gi]   = tick ? cnt_inc[gi] : fps_q[gi];
            assign stall_d[gi] = tick ? (cnt_inc[gi] == '0) : stall_q[gi];
        end
        for (gi = 0; gi < NB; gi++) begin : g_dd
            assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ? bcd_q[4*gi +: 4] + 4'd3
                                                                  : bcd_q[4*gi +: 4];
        end
    endgenerate

    assign bcd_shift = {bcd_adj[NB*4-2:0], bin_q[CNT_W-1]};

    // Out-of-range selects fall back to channel 0.
    always_comb begin
        sel_val = fps_q[0];
        for (int k = 0; k < NUM_CH; k++) begin
            if (iSEL == 3'(k)) sel_val = fps_q[k];
        end
    end

    always_comb begin
        logic [3:0] dig;
        logic [6:0] seg;
`ifdef FRM_LZ_BLANK_EN
        logic       blank_run;
        blank_run = 1'b1;
`endif
        dig     = '0;
        seg     = 7'h7F;
        hex_new = '1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            dig = bcd_shift[4*i +: 4];
            seg = seg7(dig);
`ifdef FRM_LZ_BLANK_EN
            if (blank_run && dig == 4'd0 && i != 0) seg = 7'h7F;
            else                                    blank_run = 1'b0;
`endif
            if (ovf_q) seg = 7'h3F;
            hex_new[7*i +: 7] = seg;
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        sh_d    = sh_q;
        ovf_d   = ovf_q;
        hex_d   = hex_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: if (tick || pend_q) state_d = LOAD;
            LOAD: begin
                bin_d   = sel_val;
                bcd_d   = '0;
                sh_d    = '0;
                ovf_d   = (32'(sel_val) >= OVF_LIM);
                pend_d  = 1'b0;
                state_d = SHIFT;
            end
            SHIFT: begin
                bcd_d = bcd_shift;
                bin_d = bin_q << 1;
                sh_d  = sh_q + 1'b1;
                // Decode the final shift result directly so oHEX and oVALID change together.
                if (sh_q == SH_W'(CNT_W - 1)) begin
                    hex_d   = hex_new;
                    valid_d = 1'b1;
                    state_d = SEG;
                end
            end
            SEG:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (tick && state_q != IDLE) pend_d = 1'b1;
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            meta_q  <= '0;
            sync_q  <= '0;
            dly_q   <= '0;
            wcnt_q  <= '0;
            cnt_q   <= '0;
            fps_q   <= '0;
            stall_q <= '0;
            state_q <= IDLE;
            pend_q  <= 1'b0;
            bin_q   <= '0;
            bcd_q   <= '0;
            sh_q    <= '0;
            ovf_q   <= 1'b0;
            hex_q   <= {DIGITS{7'h7F}};
            valid_q <= 1'b0;
        end else begin
            meta_q  <= iVS;
            sync_q  <= meta_q;
            dly_q   <= sync_q;
            wcnt_q  <= wcnt_d;
            cnt_q   <= cnt_d;
            fps_q   <= fps_d;
            stall_q <= stall_d;
            state_q <= state_d;
            pend_q  <= pend_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            sh_q    <= sh_d;
            ovf_q   <= ovf_d;
            hex_q   <= hex_d;
            valid_q <= valid_d;
        end
    end

    assign oFPS   = fps_q;
    assign oSTALL = stall_q;
    assign oVALID = valid_q;
    assign oHEX   = hex_q;

endmodule
